branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Pipeline control block for the 5-stage RISC-V core. It resolves conditional branches and jumps in EX and registers the redirect decision. The next cycle it steers the PC mux and squashes the three wrong-path instructions. It also detects load-use hazards, absorbs memory-busy stalls without losing a pending redirect, and keeps saturating performance counters.

## Interface
- XLEN, 32, address/PC width
- CNT_W, 32, performance counter width
- clk  in  1  core clock
- rst_n  in  1  reset, synchronous, active-low
- ex_valid  in  1  EX holds a real (non-bubble) instruction
- ex_branch  in  1  EX instruction is a conditional branch
- ex_jump  in  1  EX instruction is JAL/JALR
- ex_func3  in  3  funct3 of EX instruction
- zf, cf, vf, sf  in  1 each  ALU flags for EX compare (cf=1 means unsigned borrow, rs1<rs2)
- ex_target  in  XLEN  branch/jump target computed in EX
- id_ex_memread  in  1  ID/EX instruction is a load
- id_ex_rd  in  5  ID/EX destination register
- if_id_rs1, if_id_rs2  in  5 each  IF/ID source registers
- mem_busy  in  1  shared memory not ready; whole pipeline must freeze
- perf_clear  in  1  synchronous counter clear
- pc_sel  out  1  1 = PC takes pc_target
- pc_target  out  XLEN  registered redirect target
- pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en  out  1 each  pipeline register enables
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  insert bubble at the next edge
- cnt_branches, cnt_taken, cnt_stalls  out  CNT_W each  performance counters

## Operation
- Condition (funct3): 000 zf; 001 !zf; 100 sf!=vf; 101 sf==vf; 110 cf; 111 !cf; others 0.
- take = ex_valid & ~squash & ~mem_busy & (ex_jump | (ex_branch & cond)).
- squash = (state==REDIRECT). The instruction in EX during REDIRECT is wrong-path and is ignored.
- FSM states: RUN, REDIRECT.
  - RUN -> REDIRECT when take. target_q <= ex_target at the same edge.
  - REDIRECT -> RUN on the first cycle with mem_busy=0. REDIRECT persists while mem_busy=1.
- REDIRECT with mem_busy=0:
  - pc_sel=1, pc_target=target_q.
  - if_id_flush=id_ex_flush=ex_mem_flush=1.
  - All write enables 1.
- Load-use hazard: RUN & id_ex_memread & id_ex_rd!=0 & (id_ex_rd==if_id_rs1 | id_ex_rd==if_id_rs2).
  - Response: pc_write_en=0, if_id_write_en=0, id_ex_flush=1 for one cycle.
- mem_busy=1: all four write enables 0 and all flushes 0 (hold), regardless of state.
- Priority: reset > mem_busy hold > REDIRECT > load-use stall > normal.
  - Load-use detection is suppressed in REDIRECT because the ID instruction is wrong-path.
- Counters saturate at all-ones. perf_clear zeroes them and wins over increment.
  - cnt_branches: +1 per cycle with ex_valid & ex_branch & ~squash & ~mem_busy.
  - cnt_taken: +1 per take.
  - cnt_stalls: +1 per cycle of load-use stall or mem_busy.

## Timing
- Redirect latency: branch resolved in EX at cycle t; pc_sel/flushes asserted in t+1. Fixed 3-instruction penalty.
- Branch-taken to first correct fetch: the PC is loaded at the end of t+1.
- Back-to-back: a taken branch in EX during REDIRECT is squashed and does not count.
- Load-use stall lasts exactly one cycle. The hazard clears once the bubble enters ID/EX.
- Reset (rst_n=0 at an edge):
  - state=RUN, target_q=0, counters=0.
  - While rst_n=0, outputs: pc_sel=0, flushes 0, write enables 1, pc_target=0.
  - Reset asserted during REDIRECT drops the pending redirect.
- Outputs are combinational from state plus current inputs. Only state, target_q and counters are registered.

## Structure
- Shared package (core_pkg): funct3 branch encodings (F3_BEQ…F3_BGEU), FSM state enum, XLEN default.
- Sub-module branch_cond_eval: combinational funct3 and flags -> cond, instantiated once.
- Counters are three instances of one saturating counter pattern, inline or as sat_counter.

## Test plan
- BEQ taken: ex_valid=1, ex_branch=1, func3=000, zf=1, ex_target=0x100 at t -> t+1: pc_sel=1, pc_target=0x100, all three flushes 1; t+2 back in RUN; cnt_taken=1, cnt_branches=1.
- BLTU not taken: func3=110, cf=0 -> no redirect; cnt_branches=1, cnt_taken=0.
- Load-use: id_ex_memread=1, id_ex_rd=5, if_id_rs2=5 -> one cycle with pc_write_en=0, if_id_write_en=0, id_ex_flush=1; cnt_stalls=1. Repeat with id_ex_rd=0 -> no stall.
- Redirect under mem_busy: take at t, mem_busy=1 for t+1..t+3 -> enables 0, flushes 0, state stays REDIRECT; at t+4 pc_sel=1 with the original target; cnt_stalls=3.
- Wrong-path squash: JAL taken at t, taken BNE in EX at t+1 -> only one redirect; cnt_taken=1.
- Reset mid-REDIRECT, plus counter saturation with CNT_W=4:
  - rst_n=0 at t+1 -> no redirect afterward.
  - 20 taken branches -> cnt_taken=15.
  - perf_clear -> 0.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the core pipeline control logic.
//   - F3_*          : funct3 encodings of the RV32 conditional branches
//   - redir_state_t : redirect controller FSM state
//   - XLEN_DEF      : default address/PC width
package core_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } redir_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational branch condition from funct3 and ALU flags.
//   i_func3          funct3 of the EX instruction
//   i_zf/i_cf/i_vf/i_sf  ALU flags of rs1-rs2 (cf=1 means unsigned rs1<rs2)
//   o_cond           branch condition holds (0 for non-branch encodings)
module branch_cond_eval
  import core_pkg::*;
(
  input  logic [2:0] i_func3,
  input  logic       i_zf,
  input  logic       i_cf,
  input  logic       i_vf,
  input  logic       i_sf,
  output logic       o_cond
);

  always_comb begin
    o_cond = 1'b0;
    case (i_func3)
      F3_BEQ:  o_cond = i_zf;
      F3_BNE:  o_cond = ~i_zf;
      F3_BLT:  o_cond = i_sf ^ i_vf;
      F3_BGE:  o_cond = ~(i_sf ^ i_vf);
      F3_BLTU: o_cond = i_cf;
      F3_BGEU: o_cond = ~i_cf;
      default: o_cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: resolves branches/jumps in EX, registers the redirect,
// steers the PC and squashes wrong-path instructions one cycle later; detects
// load-use hazards, freezes on mem_busy and keeps saturating perf counters.
//   Inputs : clk, rst_n (sync, active-low), EX info (ex_valid, ex_branch,
//            ex_jump, ex_func3, zf/cf/vf/sf, ex_target), hazard info
//            (id_ex_memread, id_ex_rd, if_id_rs1, if_id_rs2), mem_busy,
//            perf_clear
//   Outputs: pc_sel, pc_target, pipeline write enables, pipeline flushes,
//            cnt_branches, cnt_taken, cnt_stalls
module branch_redirect_ctrl
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic [2:0]       ex_func3,
  input  logic             zf,
  input  logic             cf,
  input  logic             vf,
  input  logic             sf,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             mem_busy,
  input  logic             perf_clear,
  output logic             pc_sel,
  output logic [XLEN-1:0]  pc_target,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             id_ex_write_en,
  output logic             ex_mem_write_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] cnt_branches,
  output logic [CNT_W-1:0] cnt_taken,
  output logic [CNT_W-1:0] cnt_stalls
);

  redir_state_t     r_state;
  redir_state_t     w_state_nxt;
  logic [XLEN-1:0]  r_target;
  logic [CNT_W-1:0] r_cnt_br;
  logic [CNT_W-1:0] r_cnt_tk;
  logic [CNT_W-1:0] r_cnt_st;

  logic w_cond;
  logic w_squash;
  logic w_take;
  logic w_loaduse;
  logic w_br_evt;
  logic w_stall_evt;

  branch_cond_eval u_cond (
    .i_func3 (ex_func3),
    .i_zf    (zf),
    .i_cf    (cf),
    .i_vf    (vf),
    .i_sf    (sf),
    .o_cond  (w_cond)
  );

  // Whatever sits in EX while a redirect is pending is wrong-path.
  assign w_squash    = (r_state == ST_REDIRECT);
  assign w_take      = ex_valid & ~w_squash & ~mem_busy & (ex_jump | (ex_branch & w_cond));
  // The ID instruction is wrong-path during REDIRECT, so no stall for it.
  assign w_loaduse   = ~w_squash & id_ex_memread & (id_ex_rd != '0) &
                       ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2));
  assign w_br_evt    = ex_valid & ex_branch & ~w_squash & ~mem_busy;
  assign w_stall_evt = mem_busy | w_loaduse;

  always_comb begin
    w_state_nxt     = r_state;
    pc_sel          = 1'b0;
    pc_target       = r_target;
    pc_write_en     = 1'b1;
    if_id_write_en  = 1'b1;
    id_ex_write_en  = 1'b1;
    ex_mem_write_en = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    ex_mem_flush    = 1'b0;

    case (r_state)
      ST_RUN:      if (w_take)    w_state_nxt = ST_REDIRECT;
      ST_REDIRECT: if (!mem_busy) w_state_nxt = ST_RUN;
      default:                    w_state_nxt = ST_RUN;
    endcase

    if (!rst_n) begin
      pc_target = '0;
    end else if (mem_busy) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
    end else if (w_squash) begin
      pc_sel       = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (w_loaduse) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_flush    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_target <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) r_target <= ex_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || perf_clear) begin
      r_cnt_br <= '0;
      r_cnt_tk <= '0;
      r_cnt_st <= '0;
    end else begin
      if (w_br_evt    && (r_cnt_br != '1)) r_cnt_br <= r_cnt_br + CNT_W'(1);
      if (w_take      && (r_cnt_tk != '1)) r_cnt_tk <= r_cnt_tk + CNT_W'(1);
      if (w_stall_evt && (r_cnt_st != '1)) r_cnt_st <= r_cnt_st + CNT_W'(1);
    end
  end

  assign cnt_branches = r_cnt_br;
  assign cnt_taken    = r_cnt_tk;
  assign cnt_stalls   = r_cnt_st;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  localparam int K_N = 0;  // normal flow
  localparam int K_R = 1;  // redirect: pc_sel, all flushes
  localparam int K_H = 2;  // mem_busy hold
  localparam int K_S = 3;  // load-use stall

  typedef struct {
    logic             rst_n, valid, br, jmp;
    logic [2:0]       f3;
    logic             zf, cf, vf, sf;
    logic [XLEN-1:0]  target;
    logic             memread;
    logic [4:0]       rd, rs1, rs2;
    logic             busy, clr;
    // expected
    logic             sel;
    logic [XLEN-1:0]  tgt;
    logic [3:0]       we;   // {pc, if_id, id_ex, ex_mem}
    logic [2:0]       fl;   // {if_id, id_ex, ex_mem}
    logic [CNT_W-1:0] cb, ct, cs;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, ex_valid, ex_branch, ex_jump;
  logic [2:0]       ex_func3;
  logic             zf, cf, vf, sf;
  logic [XLEN-1:0]  ex_target;
  logic             id_ex_memread;
  logic [4:0]       id_ex_rd, if_id_rs1, if_id_rs2;
  logic             mem_busy, perf_clear;
  logic             pc_sel;
  logic [XLEN-1:0]  pc_target;
  logic             pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en;
  logic             if_id_flush, id_ex_flush, ex_mem_flush;
  logic [CNT_W-1:0] cnt_branches, cnt_taken, cnt_stalls;

  branch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_func3(ex_func3), .zf(zf), .cf(cf), .vf(vf), .sf(sf),
    .ex_target(ex_target), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .mem_busy(mem_busy),
    .perf_clear(perf_clear), .pc_sel(pc_sel), .pc_target(pc_target),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .id_ex_write_en(id_ex_write_en), .ex_mem_write_en(ex_mem_write_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .cnt_branches(cnt_branches), .cnt_taken(cnt_taken), .cnt_stalls(cnt_stalls)
  );

  vec_t tbl[$];
  vec_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t idle();
    vec_t v;
    v.rst_n = 1'b1; v.valid = 1'b0; v.br = 1'b0; v.jmp = 1'b0; v.f3 = 3'b000;
    v.zf = 1'b0; v.cf = 1'b0; v.vf = 1'b0; v.sf = 1'b0; v.target = '0;
    v.memread = 1'b0; v.rd = '0; v.rs1 = '0; v.rs2 = '0; v.busy = 1'b0; v.clr = 1'b0;
    v.sel = 1'b0; v.tgt = '0; v.we = 4'b1111; v.fl = 3'b000;
    v.cb = '0; v.ct = '0; v.cs = '0;
    return v;
  endfunction

  // flags ordered {zf, cf, vf, sf}
  function automatic vec_t brv(input logic [2:0] f3, input logic [3:0] flg, input logic [XLEN-1:0] t);
    vec_t v = idle();
    v.valid = 1'b1; v.br = 1'b1; v.f3 = f3;
    {v.zf, v.cf, v.vf, v.sf} = flg;
    v.target = t;
    return v;
  endfunction

  function automatic vec_t jalv(input logic [XLEN-1:0] t);
    vec_t v = idle();
    v.valid = 1'b1; v.jmp = 1'b1; v.target = t;
    return v;
  endfunction

  function automatic vec_t luv(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    vec_t v = idle();
    v.memread = 1'b1; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    return v;
  endfunction

  function automatic vec_t busyv(input vec_t b);
    vec_t v = b;
    v.busy = 1'b1;
    return v;
  endfunction

  task automatic add(input vec_t v, input int k, input logic [XLEN-1:0] tgt,
                     input int b, input int t, input int s);
    vec_t e = v;
    e.tgt = tgt;
    case (k)
      K_R:     begin e.sel = 1'b1; e.we = 4'b1111; e.fl = 3'b111; end
      K_H:     begin e.sel = 1'b0; e.we = 4'b0000; e.fl = 3'b000; end
      K_S:     begin e.sel = 1'b0; e.we = 4'b0011; e.fl = 3'b010; end
      default: begin e.sel = 1'b0; e.we = 4'b1111; e.fl = 3'b000; end
    endcase
    e.cb = CNT_W'(b); e.ct = CNT_W'(t); e.cs = CNT_W'(s);
    tbl.push_back(e);
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.rst_n; ex_valid = v.valid; ex_branch = v.br; ex_jump = v.jmp;
    ex_func3 = v.f3; zf = v.zf; cf = v.cf; vf = v.vf; sf = v.sf;
    ex_target = v.target; id_ex_memread = v.memread; id_ex_rd = v.rd;
    if_id_rs1 = v.rs1; if_id_rs2 = v.rs2; mem_busy = v.busy; perf_clear = v.clr;
  endtask

  task automatic build();
    vec_t v;
    // reset, including a taken branch on the inputs while in reset
    v = idle(); v.rst_n = 1'b0;                       add(v, K_N, 0, 0, 0, 0);
    v = brv(3'b000, 4'b1000, 32'h55); v.rst_n = 1'b0; add(v, K_N, 0, 0, 0, 0);
    add(idle(), K_N, 0, 0, 0, 0);
    // BEQ taken
    add(brv(3'b000, 4'b1000, 32'h100), K_N, 32'h0, 1, 1, 0);
    add(idle(), K_R, 32'h100, 1, 1, 0);
    add(idle(), K_N, 32'h100, 1, 1, 0);
    // BLTU not taken, then taken
    add(brv(3'b110, 4'b0000, 32'hbad0), K_N, 32'h100, 2, 1, 0);
    add(idle(), K_N, 32'h100, 2, 1, 0);
    add(brv(3'b110, 4'b0100, 32'h200), K_N, 32'h100, 3, 2, 0);
    add(idle(), K_R, 32'h200, 3, 2, 0);
    // BNE with zf=1 not taken; BGE with sf!=vf not taken; BLT taken
    add(brv(3'b001, 4'b1000, 32'hbad1), K_N, 32'h200, 4, 2, 0);
    add(brv(3'b101, 4'b0001, 32'hbad2), K_N, 32'h200, 5, 2, 0);
    add(brv(3'b100, 4'b0001, 32'h300), K_N, 32'h200, 6, 3, 0);
    add(idle(), K_R, 32'h300, 6, 3, 0);
    // reserved funct3 never taken; invalid EX neither counts nor takes
    add(brv(3'b010, 4'b1111, 32'hbad3), K_N, 32'h300, 7, 3, 0);
    v = brv(3'b000, 4'b1000, 32'hbad4); v.valid = 1'b0;
    add(v, K_N, 32'h300, 7, 3, 0);
    // load-use stall, cleared next cycle; rd=0 never stalls
    add(luv(5'd5, 5'd0, 5'd5), K_S, 32'h300, 7, 3, 1);
    add(idle(), K_N, 32'h300, 7, 3, 1);
    add(luv(5'd0, 5'd0, 5'd0), K_N, 32'h300, 7, 3, 1);
    add(luv(5'd7, 5'd7, 5'd1), K_S, 32'h300, 7, 3, 2);
    // hazard plus mem_busy: hold wins, one stall count
    add(busyv(luv(5'd7, 5'd7, 5'd1)), K_H, 32'h300, 7, 3, 3);
    v = idle(); v.clr = 1'b1;                         add(v, K_N, 32'h300, 0, 0, 0);
    // redirect held by mem_busy, with a squashed taken branch during hold
    add(jalv(32'h400), K_N, 32'h300, 0, 1, 0);
    add(busyv(idle()), K_H, 32'h400, 0, 1, 1);
    add(busyv(idle()), K_H, 32'h400, 0, 1, 2);
    add(busyv(brv(3'b000, 4'b1000, 32'h999)), K_H, 32'h400, 0, 1, 3);
    add(idle(), K_R, 32'h400, 0, 1, 3);
    add(idle(), K_N, 32'h400, 0, 1, 3);
    // taken branch under mem_busy in RUN is not taken
    add(busyv(brv(3'b000, 4'b1000, 32'h500)), K_H, 32'h400, 0, 1, 4);
    add(idle(), K_N, 32'h400, 0, 1, 4);
    // wrong-path BNE (and load-use) during REDIRECT are ignored
    add(jalv(32'h600), K_N, 32'h400, 0, 2, 4);
    v = brv(3'b001, 4'b0000, 32'h700); v.memread = 1'b1; v.rd = 5'd3; v.rs1 = 5'd3;
    add(v, K_R, 32'h600, 0, 2, 4);
    add(idle(), K_N, 32'h600, 0, 2, 4);
    // reset mid-REDIRECT drops the redirect
    add(jalv(32'h800), K_N, 32'h600, 0, 3, 4);
    v = idle(); v.rst_n = 1'b0;                       add(v, K_N, 32'h0, 0, 0, 0);
    add(idle(), K_N, 32'h0, 0, 0, 0);
    // saturation: 20 taken branches
    for (int unsigned k = 1; k <= 20; k++) begin
      logic [XLEN-1:0] t;
      logic [XLEN-1:0] tp;
      int c;
      t  = 32'h1000 + XLEN'(k * 4);
      tp = (k == 1) ? 32'h0 : 32'h1000 + XLEN'((k - 1) * 4);
      c  = (k > 15) ? 15 : int'(k);
      add(brv(3'b000, 4'b1000, t), K_N, tp, c, c, 0);
      add(idle(), K_R, t, c, c, 0);
    end
    // clear wins over a simultaneous increment; the take itself still happens
    v = brv(3'b111, 4'b0000, 32'hA00); v.clr = 1'b1;
    add(v, K_N, 32'h1050, 0, 0, 0);
    add(idle(), K_R, 32'hA00, 0, 0, 0);
  endtask

  initial begin
    vec_t e;
    build();
    drive(idle());
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      sbq.push_back(tbl[i]);
      @(negedge clk);
      e = sbq.pop_front();
      n_vec++;
      if ({pc_sel, pc_target,
           pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en,
           if_id_flush, id_ex_flush, ex_mem_flush} !== {e.sel, e.tgt, e.we, e.fl}) begin
        n_bad++;
        $display("FAIL ctrl[%0d]: got sel=%b tgt=%h we=%b%b%b%b fl=%b%b%b, want sel=%b tgt=%h we=%b fl=%b",
                 i, pc_sel, pc_target, pc_write_en, if_id_write_en, id_ex_write_en,
                 ex_mem_write_en, if_id_flush, id_ex_flush, ex_mem_flush,
                 e.sel, e.tgt, e.we, e.fl);
      end
      @(posedge clk); #1;
      n_vec++;
      if ({cnt_branches, cnt_taken, cnt_stalls} !== {e.cb, e.ct, e.cs}) begin
        n_bad++;
        $display("FAIL cnt[%0d]: got br=%0d tk=%0d st=%0d, want br=%0d tk=%0d st=%0d",
                 i, cnt_branches, cnt_taken, cnt_stalls, e.cb, e.ct, e.cs);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
